// File: rtl/msg_pkg.sv
// Shared state type and message tables for the character-message sequencer.
// The GAP state exists only when MSG_GAP_EN is defined.
package msg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    PRESENT
`ifdef MSG_GAP_EN
    , GAP
`endif
  } seq_state_t;

  localparam int MSG0_LEN = 9;
  localparam int MSG1_LEN = 7;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // "Guatemala" and "Quetzal"
  localparam logic [7:0] MSG0 [MSG0_LEN] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65,
                                             8'h6D, 8'h61, 8'h6C, 8'h61};
  localparam logic [7:0] MSG1 [MSG1_LEN] = '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A,
                                             8'h61, 8'h6C};

  // Switch patterns 00/11 pick msg0, 01/10 pick msg1.
  function automatic logic msg_of_sel(input logic [1:0] sel);
    return sel[1] ^ sel[0];
  endfunction

endpackage

// File: rtl/msg_sequencer_if.sv
// Character handshake between the sequencer (master) and its downstream consumer.
interface msg_sequencer_if;

  logic [7:0] char_out;
  logic       char_valid;
  logic       char_last;
  logic       char_ready;

  modport master (
    output char_out,
    output char_valid,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_out,
    input  char_valid,
    input  char_last,
    output char_ready
  );

endinterface

// File: rtl/msg_rom.sv
// Combinational message ROM: (msg_id, pos) -> ASCII character and message length.
module msg_rom
  import msg_pkg::*;
(
  input  logic       msg_id,
  input  logic [3:0] pos,
  output logic [7:0] char_code,
  output logic [3:0] len
);

  // Out-of-range positions read as NUL rather than aliasing into the table.
  always_comb begin
    char_code = 8'h00;
    len       = 4'(MSG0_LEN);
    if (msg_id == 1'b0) begin
      if (pos < 4'(MSG0_LEN)) char_code = MSG0[pos];
    end else begin
      len = 4'(MSG1_LEN);
      if (pos < 4'(MSG1_LEN)) char_code = MSG1[pos[2:0]];
    end
  end

endmodule

// File: rtl/msg_sequencer.sv
// Steps through the selected message one character per tick over a valid/ready handshake.
// Define MSG_GAP_EN to insert a space character between consecutive messages.
module msg_sequencer
  import msg_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] sel,
  input  logic       run,
  output logic       msg_id,
  output logic       busy,
  msg_sequencer_if.master chan
);

  seq_state_t       state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic             msg_id_q, msg_id_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] presc_q, presc_d;

  logic             tick;
  logic [7:0]       rom_char;
  logic [3:0]       rom_len;

  msg_rom u_rom (
    .msg_id    (msg_id_q),
    .pos       (pos_q),
    .char_code (rom_char),
    .len       (rom_len)
  );

  assign tick = (state_q != IDLE) && (presc_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      msg_id_q <= 1'b0;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      presc_q  <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      msg_id_q <= msg_id_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      presc_q  <= presc_d;
    end
  end

  // The prescaler free-runs outside IDLE, so ticks seen during PRESENT are simply lost.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    msg_id_d = msg_id_q;
    char_d   = char_q;
    valid_d  = valid_q;
    last_d   = last_q;
    presc_d  = presc_q;

    if (state_q != IDLE) presc_d = tick ? '0 : presc_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (run) begin
          msg_id_d = msg_of_sel(sel);
          pos_d    = '0;
          presc_d  = '0;
          state_d  = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (!run) begin
          pos_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          char_d  = rom_char;
          valid_d = 1'b1;
          last_d  = (pos_q == rom_len - 4'd1);
          state_d = PRESENT;
        end
      end

      PRESENT: begin
        if (chan.char_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            pos_d    = '0;
            msg_id_d = msg_of_sel(sel);
          end else begin
            pos_d = pos_q + 4'd1;
          end
          if (!run) begin
            pos_d   = '0;
            state_d = IDLE;
          end else begin
`ifdef MSG_GAP_EN
            state_d = last_q ? GAP : WAIT_TICK;
`else
            state_d = WAIT_TICK;
`endif
          end
        end
      end

`ifdef MSG_GAP_EN
      // GAP both waits for the tick and presents the space; char_valid tells the phases apart.
      GAP: begin
        if (valid_q) begin
          if (chan.char_ready) begin
            valid_d = 1'b0;
            state_d = run ? WAIT_TICK : IDLE;
          end
        end else if (!run) begin
          state_d = IDLE;
        end else if (tick) begin
          char_d  = CHAR_SPACE;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign chan.char_out   = char_q;
  assign chan.char_valid = valid_q;
  assign chan.char_last  = last_q;
  assign msg_id          = msg_id_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed, table-driven bench for msg_sequencer running with a 4-cycle character tick.
// Expected streams include the inter-message space when MSG_GAP_EN is defined.
module tb_msg_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b0;
  logic       run   = 1'b0;
  logic [1:0] sel   = 2'b00;
  logic       msg_id;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  msg_sequencer_if chan ();

  msg_sequencer #(
    .TICK_DIV (4),
    .DIV_W    (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .sel    (sel),
    .run    (run),
    .msg_id (msg_id),
    .busy   (busy),
    .chan   (chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] chr;
    logic       last;
    logic       id;
    int         gap;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] s, input logic [7:0] c, input logic l,
                         input logic i, input int g);
    vec_t v;
    v.sel  = s;
    v.chr  = c;
    v.last = l;
    v.id   = i;
    v.gap  = g;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic e, input logic r, input logic [1:0] s, input logic rdy);
    ena             = e;
    run             = r;
    sel             = s;
    chan.char_ready = rdy;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns the number of negedges stepped until char_valid is seen.
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (chan.char_valid !== 1'b1 && cycles < budget);
    if (chan.char_valid !== 1'b1) check_output("valid timeout", {31'b0, chan.char_valid}, 32'd1);
  endtask

  task automatic check_char(input string name, input int cyc, input int exp_cyc,
                            input logic [7:0] c, input logic id);
    check_output({name, " interval"}, cyc, exp_cyc);
    check_output({name, " char"}, chan.char_out, c);
    check_output({name, " msg_id"}, msg_id, id);
  endtask

  initial begin
    int cyc;
    chan.char_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    check_output("reset char_out", chan.char_out, 8'h00);
    check_output("reset valid", chan.char_valid, 1'b0);
    check_output("reset last", chan.char_last, 1'b0);
    check_output("reset msg_id", msg_id, 1'b0);
    check_output("reset busy", busy, 1'b0);

    // msg0 with sel=00, wrap into msg0 again via sel=11, sel=01 mid-message, then msg1.
    add_vec(2'b00, 8'h47, 1'b0, 1'b0, 5);
    add_vec(2'b00, 8'h75, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h61, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h74, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h65, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h6D, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h61, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h6C, 1'b0, 1'b0, 4);
    add_vec(2'b00, 8'h61, 1'b1, 1'b0, 4);
`ifdef MSG_GAP_EN
    add_vec(2'b11, 8'h20, 1'b0, 1'b0, 4);
`endif
    add_vec(2'b11, 8'h47, 1'b0, 1'b0, 4);
    add_vec(2'b11, 8'h75, 1'b0, 1'b0, 4);
    add_vec(2'b11, 8'h61, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h74, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h65, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h6D, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h61, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h6C, 1'b0, 1'b0, 4);
    add_vec(2'b01, 8'h61, 1'b1, 1'b0, 4);
`ifdef MSG_GAP_EN
    add_vec(2'b01, 8'h20, 1'b0, 1'b1, 4);
`endif
    add_vec(2'b01, 8'h51, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h75, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h65, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h74, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h7A, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h61, 1'b0, 1'b1, 4);
    add_vec(2'b10, 8'h6C, 1'b1, 1'b1, 4);
`ifdef MSG_GAP_EN
    add_vec(2'b00, 8'h20, 1'b0, 1'b0, 4);
`endif
    add_vec(2'b00, 8'h47, 1'b0, 1'b0, 4);

    run = 1'b1;
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      wait_valid(12, cyc);
      check_char($sformatf("vec%0d", i), cyc, vecs[i].gap, vecs[i].chr, vecs[i].id);
      check_output($sformatf("vec%0d last", i), chan.char_last, vecs[i].last);
    end

    // Back-pressure on 74: outputs hold, ticks during the stall are dropped.
    wait_valid(12, cyc);
    check_char("bp 75", cyc, 4, 8'h75, 1'b0);
    wait_valid(12, cyc);
    check_char("bp 61", cyc, 4, 8'h61, 1'b0);
    wait_valid(12, cyc);
    check_char("bp 74", cyc, 4, 8'h74, 1'b0);
    chan.char_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_output($sformatf("hold%0d char", i), chan.char_out, 8'h74);
      check_output($sformatf("hold%0d valid", i), chan.char_valid, 1'b1);
    end
    // The stall leaves the prescaler at 2, so the next tick is two cycles after release.
    chan.char_ready = 1'b1;
    wait_valid(12, cyc);
    check_char("release 65", cyc, 2, 8'h65, 1'b0);

    // Drop run while 6D is presented: handshake completes, then idle.
    wait_valid(12, cyc);
    check_char("stop 6D", cyc, 4, 8'h6D, 1'b0);
    run = 1'b0;
    step();
    check_output("stop busy", busy, 1'b0);
    check_output("stop valid", chan.char_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("idle%0d valid", i), chan.char_valid, 1'b0);
    end
    run = 1'b1;
    wait_valid(12, cyc);
    check_char("restart 47", cyc, 5, 8'h47, 1'b0);

    // Drop run in WAIT_TICK: idle next cycle, then restart on msg1 from position 0.
    step();
    run = 1'b0;
    step();
    check_output("wait drop busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("wait drop%0d valid", i), chan.char_valid, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, 2'b01, 1'b1);
    wait_valid(12, cyc);
    check_char("msg1 restart 51", cyc, 5, 8'h51, 1'b1);

    // Freeze mid-count for 5 cycles: next character is 5 cycles later than usual.
    step();
    ena = 1'b0;
    repeat (5) step();
    check_output("freeze busy", busy, 1'b1);
    check_output("freeze valid", chan.char_valid, 1'b0);
    ena = 1'b1;
    wait_valid(12, cyc);
    check_char("after freeze 75", cyc, 3, 8'h75, 1'b1);

    // Freeze while presenting with ready high: no transfer may happen.
    ena = 1'b0;
    repeat (3) step();
    check_output("freeze present valid", chan.char_valid, 1'b1);
    check_output("freeze present char", chan.char_out, 8'h75);
    ena = 1'b1;
    wait_valid(12, cyc);
    check_char("after present freeze 65", cyc, 4, 8'h65, 1'b1);

    // Asynchronous reset in the middle of a stalled handshake.
    chan.char_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async valid", chan.char_valid, 1'b0);
    check_output("async char_out", chan.char_out, 8'h00);
    check_output("async last", chan.char_last, 1'b0);
    check_output("async msg_id", msg_id, 1'b0);
    check_output("async busy", busy, 1'b0);
    step();
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1);
    rst_n = 1'b1;
    step();
    check_output("post reset busy", busy, 1'b0);
    check_output("post reset valid", chan.char_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
